// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: widths, opcode field, FSM encoding.
// Opcode constants used by the control unit live here as well.
package fetch_stage_pkg;

  localparam int IW_DEF  = 16;
  localparam int PCW_DEF = 8;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND = 4'h3;
  localparam logic [OPC_W-1:0] OP_LD  = 4'h8;
  localparam logic [OPC_W-1:0] OP_ST  = 4'h9;
  localparam logic [OPC_W-1:0] OP_BEQ = 4'hC;
  localparam logic [OPC_W-1:0] OP_JMP = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fstate_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its pc.
// Ports: load_i/unload_i/clear_i controls, data_i/pc_i in, valid_o/data_o/pc_o out.
module fetch_skid
  import fetch_stage_pkg::*;
#(
  parameter int IW  = IW_DEF,
  parameter int PCW = PCW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           unload_i,
  input  logic           clear_i,
  input  logic [IW-1:0]  data_i,
  input  logic [PCW-1:0] pc_i,
  output logic           valid_o,
  output logic [IW-1:0]  data_o,
  output logic [PCW-1:0] pc_o
);

  logic           valid_q;
  logic [IW-1:0]  data_q;
  logic [PCW-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: pc, imem handshake, IF/ID register, skid on stall.
// Ports: imem_req/addr/ack/rdata, stall, redirect(+pc), id_valid/inst/pc/opcode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          IW       = IW_DEF,
  parameter int          PCW      = PCW_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PCW-1:0]   imem_addr,
  input  logic             imem_ack,
  input  logic [IW-1:0]    imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PCW-1:0]   redirect_pc,
  output logic             id_valid,
  output logic [IW-1:0]    id_inst,
  output logic [PCW-1:0]   id_pc,
  output logic [OPC_W-1:0] id_opcode
);

  fstate_e        state_q;
  logic           req_q;
  logic [PCW-1:0] pc_q;
  logic           id_valid_q;
  logic [IW-1:0]  id_inst_q;
  logic [PCW-1:0] id_pc_q;

  logic           skid_ld;
  logic           skid_ul;
  logic           skid_vld;
  logic [IW-1:0]  skid_data;
  logic [PCW-1:0] skid_pc;

  // Skid control mirrors the FSM transitions below; redirect overrides both.
  always_comb begin
    skid_ld = 1'b0;
    skid_ul = 1'b0;
    if (!redirect) begin
      skid_ld = (state_q == S_WAIT) && imem_ack && stall;
      skid_ul = (state_q == S_HOLD) && !stall;
    end
  end

  fetch_skid #(
    .IW  (IW),
    .PCW (PCW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_ld),
    .unload_i (skid_ul),
    .clear_i  (redirect),
    .data_i   (imem_rdata),
    .pc_i     (pc_q),
    .valid_o  (skid_vld),
    .data_o   (skid_data),
    .pc_o     (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      pc_q       <= PCW'(RESET_PC);
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
    end else if (redirect) begin
      // Flush wins over stall and drops any same-cycle ack data.
      state_q    <= S_WAIT;
      req_q      <= 1'b1;
      pc_q       <= redirect_pc;
      id_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_WAIT;
          req_q   <= 1'b1;
          if (!stall) id_valid_q <= 1'b0;
        end
        S_WAIT: begin
          if (imem_ack) begin
            pc_q <= pc_q + PCW'(1);
            if (stall) begin
              state_q <= S_HOLD;
              req_q   <= 1'b0;
            end else begin
              id_valid_q <= 1'b1;
              id_inst_q  <= imem_rdata;
              id_pc_q    <= pc_q;
            end
          end else if (!stall) begin
            id_valid_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            state_q    <= S_WAIT;
            req_q      <= 1'b1;
            id_valid_q <= skid_vld;
            id_inst_q  <= skid_data;
            id_pc_q    <= skid_pc;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_opcode = id_inst_q[OPC_HI:OPC_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_fetch_stage;

  localparam int IW  = 16;
  localparam int PCW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_ack;
  logic [IW-1:0]  imem_rdata;
  logic           stall;
  logic           redirect;
  logic [PCW-1:0] redirect_pc;
  logic           id_valid;
  logic [IW-1:0]  id_inst;
  logic [PCW-1:0] id_pc;
  logic [3:0]     id_opcode;

  logic [IW-1:0]  mem [256];

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_stage #(
    .IW       (IW),
    .PCW      (PCW),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_opcode   (id_opcode)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: fetching whenever started and nothing parked;
  // a parked instruction lives in a small queue until stall drops.
  int m_pc;
  bit m_idle;
  bit m_v;
  int m_inst;
  int m_ipc;
  int sk_inst[$];
  int sk_pc[$];

  task automatic model(input bit r, input bit a, input bit s,
                       input bit rd, input int rpc);
    if (!r) begin
      m_pc = 0; m_idle = 1; m_v = 0; m_inst = 0; m_ipc = 0;
      sk_inst.delete(); sk_pc.delete();
    end else if (rd) begin
      m_pc = rpc % 256; m_v = 0; m_idle = 0;
      sk_inst.delete(); sk_pc.delete();
    end else if (m_idle) begin
      m_idle = 0;
      if (!s) m_v = 0;
    end else if (sk_inst.size() != 0) begin
      if (!s) begin
        m_v = 1;
        m_inst = sk_inst.pop_front();
        m_ipc = sk_pc.pop_front();
      end
    end else if (a) begin
      if (s) begin
        sk_inst.push_back(int'(mem[m_pc]));
        sk_pc.push_back(m_pc);
      end else begin
        m_v = 1; m_inst = int'(mem[m_pc]); m_ipc = m_pc;
      end
      m_pc = (m_pc + 1) % 256;
    end else if (!s) begin
      m_v = 0;
    end
  endtask

  task automatic step(input bit r, input bit a, input bit s,
                      input bit rd, input int rpc);
    bit e_req;
    rst_n = r; imem_ack = a; stall = s;
    redirect = rd; redirect_pc = PCW'(rpc);
    @(posedge clk);
    model(r, a, s, rd, rpc);
    @(negedge clk);
    e_req = !m_idle && (sk_inst.size() == 0);
    chk("req",  32'(imem_req),  32'(e_req));
    chk("addr", 32'(imem_addr), 32'(m_pc));
    chk("vld",  32'(id_valid),  32'(m_v));
    chk("inst", 32'(id_inst),   32'(m_inst));
    chk("idpc", 32'(id_pc),     32'(m_ipc));
    chk("opc",  32'(id_opcode), 32'(m_inst >> 12));
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789;

    // Reset and back-to-back fetch
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("rst_req",  32'(imem_req), 0);
    chk("rst_vld",  32'(id_valid), 0);
    chk("rst_inst", 32'(id_inst),  0);
    chk("rst_addr", 32'(imem_addr), 0);
    step(1, 1, 0, 0, 0);
    chk("idle_vld", 32'(id_valid), 0);
    chk("wait_req", 32'(imem_req), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0);
      chk("b2b_pc",  32'(id_pc),     32'(i));
      chk("b2b_opc", 32'(id_opcode), 32'(i + 1));
      chk("b2b_vld", 32'(id_valid),  1);
    end

    // Stall with ack at pc=5
    step(1, 0, 0, 1, 4);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0);
      chk("hold_pc",  32'(id_pc),    4);
      chk("hold_vld", 32'(id_valid), 1);
      chk("hold_req", 32'(imem_req), 0);
    end
    step(1, 0, 0, 0, 0);
    chk("rel_pc",   32'(id_pc),     5);
    chk("rel_vld",  32'(id_valid),  1);
    chk("rel_addr", 32'(imem_addr), 6);
    step(1, 1, 0, 0, 0);
    chk("res_pc", 32'(id_pc), 6);

    // Redirect with ack and stall
    step(1, 1, 1, 1, 'h40);
    chk("rd_vld",  32'(id_valid),  0);
    chk("rd_addr", 32'(imem_addr), 'h40);
    step(1, 1, 0, 0, 0);
    chk("rd_pc",  32'(id_pc),    'h40);
    chk("rd_vld2", 32'(id_valid), 1);

    // pc wrap
    step(1, 0, 0, 1, 'hFF);
    step(1, 1, 0, 0, 0);
    chk("wrap_addr", 32'(imem_addr), 0);
    chk("wrap_pc",   32'(id_pc),     'hFF);

    // Ack low for 4 cycles
    a0 = int'(imem_addr);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      chk("nack_addr", 32'(imem_addr), 32'(a0));
      chk("nack_vld",  32'(id_valid),  0);
    end
    step(1, 1, 0, 0, 0);
    chk("nack_ld",  32'(id_valid),  1);
    chk("nack_pc",  32'(id_pc),     32'(a0));
    chk("nack_nxt", 32'(imem_addr), 32'((a0 + 1) % 256));

    // Reset while in HOLD
    step(1, 1, 1, 0, 0);
    chk("pre_rst_req", 32'(imem_req), 0);
    step(0, 1, 0, 0, 0);
    chk("hrst_req",  32'(imem_req),  0);
    chk("hrst_vld",  32'(id_valid),  0);
    chk("hrst_inst", 32'(id_inst),   0);
    chk("hrst_idpc", 32'(id_pc),     0);
    chk("hrst_addr", 32'(imem_addr), 0);
    step(1, 1, 0, 0, 0);
    chk("hidle_vld", 32'(id_valid), 0);
    chk("hidle_req", 32'(imem_req), 1);
    step(1, 1, 0, 0, 0);
    chk("hfirst_pc",  32'(id_pc),    0);
    chk("hfirst_vld", 32'(id_valid), 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, a, s, rd;
      int rpc;
      if ($urandom_range(0, 19) == 0)
        mem[$urandom_range(0, 255)] = IW'($urandom);
      r   = ($urandom_range(0, 63) != 0);
      a   = ($urandom_range(0, 1) == 1);
      s   = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      step(r, a, s, rd, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter IW, default 16: instruction width; opcode is bits [15:12].
REQ-002 SHALL have parameter PCW, default 8: PC width, word address.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, synchronous, active-low.
REQ-006 SHALL have port imem_req  out  1: fetch request to instruction memory.
REQ-007 SHALL have port imem_addr  out  PCW: fetch address, equal to pc.
REQ-008 SHALL have port imem_ack  in  1: imem_rdata valid for the current-cycle imem_addr.
REQ-009 SHALL have port imem_rdata  in  IW: fetched instruction.
REQ-010 SHALL have port stall  in  1: decode/execute cannot accept; hold IF/ID.
REQ-011 SHALL have port redirect  in  1: taken branch, flush and refetch.
REQ-012 SHALL have port redirect_pc  in  PCW: branch target.
REQ-013 SHALL have port id_valid  out  1: IF/ID holds a live instruction.
REQ-014 SHALL have port id_inst  out  IW: IF/ID instruction.
REQ-015 SHALL have port id_pc  out  PCW: address of id_inst.
REQ-016 SHALL have port id_opcode  out  4: id_inst[15:12], drives the control unit opcode input.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, HOLD.
REQ-018 SHALL make IDLE last exactly one cycle after reset release with imem_req=0, then enter WAIT.
REQ-019 SHALL assert imem_req=1 in WAIT, with imem_addr=pc held stable until ack or redirect.
REQ-020 SHALL, when WAIT and imem_ack=1 and stall=0, load id_inst<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+1, and stay in WAIT (zero-bubble back-to-back fetch).
REQ-021 SHALL, when WAIT and imem_ack=1 and stall=1, capture rdata and pc into a one-entry skid buffer, set pc<=pc+1, enter HOLD, and leave IF/ID unchanged.
REQ-022 SHALL deassert imem_req in HOLD and in IDLE.
REQ-023 SHALL, when HOLD and stall=0, move the skid entry into IF/ID (id_valid=1), empty the skid, and enter WAIT.
REQ-024 SHALL, when stall=0 and no instruction is loaded this cycle, clear id_valid to 0 (bubble).
REQ-025 SHALL hold id_valid, id_inst and id_pc unchanged while stall=1, unless redirect=1.
REQ-026 SHALL give redirect absolute priority in any state: pc<=redirect_pc, id_valid<=0, skid emptied, same-cycle ack data discarded with no pc increment, state<=WAIT.
REQ-027 SHALL flush on simultaneous redirect and stall (id_valid=0); the flush wins.
REQ-028 SHALL increment pc modulo 2^PCW (255 -> 0 at PCW=8).
REQ-029 SHALL give a fetch latency of 1 cycle from ack to id_valid, and of 2 cycles minimum from redirect to the first redirected instruction in IF/ID.
REQ-030 SHALL drive id_opcode combinationally from id_inst.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, set pc=RESET_PC, state=IDLE, imem_req=0, id_valid=0, id_inst=0, id_pc=0, skid empty.
REQ-032 SHALL abandon any outstanding request on reset mid-operation and ignore imem_ack while rst_n=0.

Structure
REQ-033 SHALL place the opcode field position, the IW/PCW defaults and the FSM state encoding in the shared definitions package, alongside the existing opcode constants.
REQ-034 SHALL implement the one-entry skid buffer as sub-module fetch_skid (load, unload, clear; data+pc+valid).

Verification
REQ-035 SHALL verify: reset, then ack every cycle, stall=0, mem[0..2]=0x1123,0x2456,0x3789 -> id_pc 0,1,2 on consecutive cycles, id_opcode 1,2,3, no bubbles.
REQ-036 SHALL verify: stall=1 for 3 cycles while ack=1 at pc=5 -> IF/ID frozen, state HOLD, imem_req=0; on release id_pc=5, then fetch resumes at 6.
REQ-037 SHALL verify: redirect=1, redirect_pc=0x40, with ack and stall=1 in the same cycle -> id_valid=0 next cycle, pc=0x40, then id_pc=0x40.
REQ-038 SHALL verify: pc=0xFF with ack -> next imem_addr=0x00.
REQ-039 SHALL verify: ack held low for 4 cycles -> imem_addr stable, id_valid=0 throughout, then a single load.
REQ-040 SHALL verify: rst_n=0 asserted while in HOLD -> all outputs at reset values next edge, IDLE one cycle after release, first fetch at RESET_PC.
